// File: rtl/core_fetch_queue_pkg.sv
// Shared types and default sizes for the instruction fetch queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_fetch_queue_pkg;

  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned MAX_OUT_DEF = 2;

  // Word pointer (byte address = {ptr, 2'b00}) and instruction word.
  typedef logic [ADDR_W_DEF-1:0] ptr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  // One buffered instruction together with the pointer it was fetched from.
  typedef struct packed {
    ptr_t  pc;
    word_t insn;
  } fetch_entry_t;

endpackage

// File: rtl/core_fetch_queue_if.sv
// Instruction bus and decode handshake bundle for the fetch queue.
// Latency: n/a (wires only).
// Backpressure: mem_ready throttles requests, stall holds the decode head.
interface core_fetch_queue_if
  import core_fetch_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;
  logic              insn_valid;
  logic [DATA_W-1:0] insn;
  logic [ADDR_W-1:0] insn_pc;

  // Fetch unit side.
  modport master (
    output mem_req, mem_addr,
    input  mem_ready, mem_rvalid, mem_rdata,
    input  stall,
    output insn_valid, insn, insn_pc
  );

  // Bus / decode environment side.
  modport slave (
    input  mem_req, mem_addr,
    output mem_ready, mem_rvalid, mem_rdata,
    output stall,
    input  insn_valid, insn, insn_pc
  );

endinterface

// File: rtl/core_fetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with push/pop/clear and occupancy count.
// Latency: pushed data visible at the head the cycle after the push (no bypass).
// Backpressure: none internally; the caller's credit scheme keeps pushes within capacity.
module core_fetch_queue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 62,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for indices and count; clear wins over a same-cycle push or pop.
  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_idx_d = wr_idx_q + IDX_W'(1);
      if (pop_i)  rd_idx_d = rd_idx_q + IDX_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Index and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_idx_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_idx_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !clear_i && count_q == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && !clear_i && count_q == '0));

endmodule

// File: rtl/core_fetch_queue.sv
// Instruction fetch front end: credit-limited word reads, in-order prefetch FIFO, redirect handling.
// Latency: first request the cycle after reset release or a redirect; an instruction reaches decode one cycle after its return.
// Backpressure: stall holds the FIFO head; requests stop when outstanding or FIFO credit runs out.
// Build option: define CORE_FETCH_ALIGN_FAULT_EN to flag misaligned PC writes on align_fault.
module core_fetch_queue
  import core_fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W          = ADDR_W_DEF,
  parameter int unsigned       DATA_W          = DATA_W_DEF,
  parameter int unsigned       DEPTH           = DEPTH_DEF,
  parameter int unsigned       MAX_OUTSTANDING = MAX_OUT_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                branch,
  input  logic                flush,
  input  logic                wr_pc,
  input  logic [ADDR_W-1:0]   branch_target,
  input  logic [DATA_W-1:0]   wr_current,
  output logic                align_fault,
  core_fetch_queue_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t MAX_OUT_C = cnt_t'(MAX_OUTSTANDING);
  localparam cnt_t DEPTH_C   = cnt_t'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] insn;
  } entry_t;

  logic              run_q;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0] ret_ptr_q, ret_ptr_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  cnt_t              outst_q, outst_d;
  cnt_t              discard_q, discard_d;

  logic              redirect, accept, ret, drop, push, pop, credit_ok;
  logic [ADDR_W-1:0] target, wr_ptr, head_pc_inc;
  entry_t            push_ent, head_ent;
  cnt_t              fifo_cnt;
  logic              fifo_empty;

  assign redirect    = branch | flush;
  assign ret         = bus.mem_rvalid;
  assign pop         = bus.insn_valid & ~bus.stall;
  assign wr_ptr      = ADDR_W'(wr_current >> 2);
  assign head_pc_inc = head_ent.pc + ADDR_W'(1);

`ifdef CORE_FETCH_ALIGN_FAULT_EN
  assign align_fault = branch & wr_pc & (wr_current[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  // Redirect target: branch source first, otherwise the instruction after the last one consumed.
  always_comb begin
    target = next_pc_q;
    if (branch)   target = wr_pc ? wr_ptr : branch_target;
    else if (pop) target = head_pc_inc;
  end

  // FIFO credit covers both buffered and in-flight words, so a return always has a slot.
  assign credit_ok   = ({1'b0, fifo_cnt} + {1'b0, outst_q}) < {1'b0, DEPTH_C};
  assign bus.mem_req  = run_q & ~redirect & (outst_q < MAX_OUT_C) & credit_ok;
  assign bus.mem_addr = fetch_ptr_q;
  assign accept      = bus.mem_req & bus.mem_ready;

  // A return is stale if it lands on a redirect cycle or while older stale reads are pending.
  assign drop = ret & (redirect | (discard_q != '0));
  assign push = ret & ~drop;

  // Outstanding and discard counters. On a redirect every read still in flight is stale,
  // which already includes any discard carried over from an earlier redirect.
  always_comb begin
    outst_d = outst_q;
    case ({accept, ret})
      2'b10:   outst_d = outst_q + cnt_t'(1);
      2'b01:   outst_d = outst_q - cnt_t'(1);
      default: outst_d = outst_q;
    endcase
    discard_d = discard_q;
    if (redirect)                      discard_d = outst_d;
    else if (ret && discard_q != '0)   discard_d = discard_q - cnt_t'(1);
  end

  // Fetch, return and architectural pointers.
  always_comb begin
    fetch_ptr_d = fetch_ptr_q;
    ret_ptr_d   = ret_ptr_q;
    next_pc_d   = next_pc_q;
    if (redirect) begin
      fetch_ptr_d = target;
      ret_ptr_d   = target;
      next_pc_d   = target;
    end else begin
      if (accept) fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
      if (push)   ret_ptr_d   = ret_ptr_q + ADDR_W'(1);
      if (pop)    next_pc_d   = head_pc_inc;
    end
  end

  // State registers; run_q holds requests off until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      fetch_ptr_q <= RESET_PC;
      ret_ptr_q   <= RESET_PC;
      next_pc_q   <= RESET_PC;
      outst_q     <= '0;
      discard_q   <= '0;
    end else begin
      run_q       <= 1'b1;
      fetch_ptr_q <= fetch_ptr_d;
      ret_ptr_q   <= ret_ptr_d;
      next_pc_q   <= next_pc_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
    end
  end

  assign push_ent.pc   = ret_ptr_q;
  assign push_ent.insn = bus.mem_rdata;

  core_fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (redirect),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_dat_o (head_ent),
    .count_o    (fifo_cnt),
    .empty_o    (fifo_empty)
  );

  assign bus.insn_valid = ~fifo_empty;
  assign bus.insn       = head_ent.insn;
  assign bus.insn_pc    = head_ent.pc;

  a_rvalid_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_rvalid |-> (outst_q != '0));
  a_discard_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    discard_q <= outst_q);

endmodule

// File: tb/tb_core_fetch_queue.sv
`timescale 1ns/1ps
module tb_core_fetch_queue;
  import core_fetch_queue_pkg::*;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

`ifdef CORE_FETCH_ALIGN_FAULT_EN
  localparam logic AF_EXP = 1'b1;
`else
  localparam logic AF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          branch = 1'b0;
  logic          flush = 1'b0;
  logic          wr_pc = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [DW-1:0] wr_current = '0;
  logic          align_fault;

  core_fetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  core_fetch_queue #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC('0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch        (branch),
    .flush         (flush),
    .wr_pc         (wr_pc),
    .branch_target (branch_target),
    .wr_current    (wr_current),
    .align_fault   (align_fault),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_deliv  = 0;
  logic ret_hold  = 1'b0;
  logic rand_mode = 1'b0;
  logic use_model = 1'b0;
  logic [AW-1:0] model_pc = '0;

  fetch_entry_t  exp_q[$];
  logic [AW-1:0] exp_addr[$];
  logic [AW-1:0] inflight[$];

  function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
    return {2'b10, a} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_exp(input logic [AW-1:0] first, input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = first + AW'(i);
      e.insn = memword(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_addr(input logic [AW-1:0] first, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(first + AW'(i));
  endtask

  task automatic wait_exp_empty(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
    check({name, "_insn_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    for (int i = 0; i < budget && n_acc < n; i++) tick(1);
    check(name, 64'(n_acc >= n), 64'd1);
  endtask

  task automatic wait_deliv(input int n, input int budget, input string name);
    for (int i = 0; i < budget && n_deliv < n; i++) tick(1);
    check(name, 64'(n_deliv >= n), 64'd1);
  endtask

  // Reset with all stimulus idle; reset-state outputs checked while rst_n is low.
  task automatic do_reset();
    rst_n = 1'b0;
    branch = 1'b0; flush = 1'b0; wr_pc = 1'b0;
    bus.stall = 1'b0;
    use_model = 1'b0; ret_hold = 1'b0; rand_mode = 1'b0;
    model_pc = '0;
    exp_q.delete(); exp_addr.delete();
    n_acc = 0; n_deliv = 0;
    tick(2);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_insn_valid", 64'(bus.insn_valid), 64'd0);
    check("rst_align_fault", 64'(align_fault), 64'd0);
    rst_n = 1'b1;
  endtask

  // Bus model: records accepts at the negedge, returns them in order after the next edge.
  initial begin : bus_model
    logic [AW-1:0] a;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_req && bus.mem_ready) begin
        n_acc++;
        inflight.push_back(bus.mem_addr);
        if (exp_addr.size() != 0) check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
      end
      @(posedge clk); #2;
      if (!rst_n) begin
        inflight.delete();
        bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      end else begin
        bus.mem_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (inflight.size() != 0 && !ret_hold && (!rand_mode || $urandom_range(0, 2) != 0)) begin
          a = inflight.pop_front();
          bus.mem_rvalid = 1'b1; bus.mem_rdata = memword(a);
        end else begin
          bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        end
      end
    end
  end

  // Decode-side monitor: scoreboard queue for directed runs, architectural PC model for random runs.
  initial begin : insn_monitor
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.insn_valid && !bus.stall) begin
          n_deliv++;
          if (use_model) begin
            check("model_pc", 64'(bus.insn_pc), 64'(model_pc));
            check("model_insn", 64'(bus.insn), 64'(memword(model_pc)));
            model_pc = model_pc + AW'(1);
          end else if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_insn: pc 0x%0h delivered, nothing expected", bus.insn_pc);
          end else begin
            e = exp_q.pop_front();
            check("insn_pc", 64'(bus.insn_pc), 64'(e.pc));
            check("insn", 64'(bus.insn), 64'(e.insn));
          end
        end
        if (use_model && branch) model_pc = wr_pc ? AW'(wr_current >> 2) : branch_target;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int snap;
    bus.stall = 1'b0;

    // 1: straight-line fetch, sequential addresses, one instruction per cycle once filled.
    do_reset();
    push_exp('0, 20);
    push_addr('0, 20);
    @(negedge clk);
    check("t1_req_first_cycle", 64'(bus.mem_req), 64'd0);
    wait_deliv(2, 20, "t1_first_deliv");
    snap = n_deliv;
    tick(10);
    check("t1_throughput", 64'(n_deliv - snap), 64'd10);
    wait_exp_empty(40, "t1");
    bus.stall = 1'b1;

    // 2: decode stalled, exactly DEPTH words fetched then requests stop until a pop.
    do_reset();
    bus.stall = 1'b1;
    tick(20);
    check("t2_accepts", 64'(n_acc), 64'd4);
    @(negedge clk);
    check("t2_req_held", 64'(bus.mem_req), 64'd0);
    check("t2_head_valid", 64'(bus.insn_valid), 64'd1);
    check("t2_head_pc", 64'(bus.insn_pc), 64'd0);
    @(posedge clk); #1;
    push_exp('0, 8);
    push_addr(AW'(4), 4);
    bus.stall = 1'b0;
    wait_exp_empty(40, "t2");
    bus.stall = 1'b1;

    // 3: branch with two reads outstanding; both stale returns dropped (one on the branch cycle).
    do_reset();
    ret_hold = 1'b1;
    push_addr('0, 2);
    push_addr(AW'('h100), 3);
    wait_acc(2, 20, "t3_two_out");
    tick(3);
    @(negedge clk);
    check("t3_req_limited", 64'(bus.mem_req), 64'd0);
    @(posedge clk); #1;
    branch = 1'b1; branch_target = AW'('h100); ret_hold = 1'b0;
    push_exp(AW'('h100), 8);
    @(negedge clk);
    check("t3_req_on_redirect", 64'(bus.mem_req), 64'd0);
    check("t3_no_align_fault", 64'(align_fault), 64'd0);
    @(posedge clk); #1;
    branch = 1'b0;
    @(negedge clk);
    check("t3_fifo_empty", 64'(bus.insn_valid), 64'd0);
    wait_exp_empty(60, "t3");
    bus.stall = 1'b1;

    // 4: head pc 7 consumed on the flush cycle; refetch resumes at 8.
    do_reset();
    bus.stall = 1'b1;
    push_addr('0, 4);
    push_addr(AW'(7), 4);
    push_addr(AW'(8), 4);
    tick(12);
    check("t4_fill", 64'(n_acc), 64'd4);
    branch = 1'b1; branch_target = AW'(7);
    tick(1);
    branch = 1'b0;
    tick(12);
    @(negedge clk);
    check("t4_head_pc", 64'(bus.insn_pc), 64'd7);
    @(posedge clk); #1;
    push_exp(AW'(7), 8);
    bus.stall = 1'b0; flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_exp_empty(60, "t4");
    bus.stall = 1'b1;

    // 5: branch+flush+wr_pc with a misaligned written PC rounds down to 0x100.
    do_reset();
    bus.stall = 1'b1;
    push_addr('0, 4);
    push_addr(AW'('h100), 2);
    tick(10);
    branch = 1'b1; flush = 1'b1; wr_pc = 1'b1;
    wr_current = 32'h0000_0402; branch_target = AW'('h55);
    push_exp(AW'('h100), 6);
    @(negedge clk);
    check("t5_align_fault", 64'(align_fault), 64'(AF_EXP));
    @(posedge clk); #1;
    branch = 1'b0; flush = 1'b0; wr_pc = 1'b0; bus.stall = 1'b0;
    @(negedge clk);
    check("t5_align_fault_clear", 64'(align_fault), 64'd0);
    wait_exp_empty(60, "t5");
    bus.stall = 1'b1;

    // 6: random bus timing, stalls and redirects against the architectural PC model.
    do_reset();
    rand_mode = 1'b1;
    use_model = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      int r;
      r = int'($urandom_range(0, 31));
      bus.stall     = ($urandom_range(0, 3) == 0);
      branch        = (r == 0);
      flush         = (r == 1);
      wr_pc         = ($urandom_range(0, 1) == 1);
      wr_current    = DW'($urandom_range(0, 16383));
      branch_target = AW'($urandom_range(0, 4095));
      tick(1);
    end
    branch = 1'b0; flush = 1'b0; wr_pc = 1'b0;
    check("t6_progress", 64'(n_deliv > 300), 64'd1);
    bus.stall = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
